// File: rtl/ram_1r1w_be.sv
// Parametrised 1R1W synchronous RAM with byte enables, write-first collision bypass
// and a zero-clear sweep after reset or on ram_clr. Define RAM_OUT_REG_EN for a 2-cycle read path.
module ram_1r1w_be #(
  parameter  int DW    = 32,
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH),
  localparam int BW    = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ram_radr,
  input  logic          ram_ren,
  output logic [DW-1:0] ram_rdata,
  output logic          ram_rvld,
  input  logic [AW-1:0] ram_wadr,
  input  logic [DW-1:0] ram_wdata,
  input  logic          ram_wen,
  input  logic [BW-1:0] ram_wbe,
  input  logic          ram_clr,
  output logic          init_busy
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t          state_r;
  logic [AW-1:0]   cnt_r;
  logic            init_busy_r;
  logic            last_s;
  logic            accept_rd_s;
  logic            accept_wr_s;

  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   raw_r;
  logic            hit_r;
  logic [BW-1:0]   byp_be_r;
  logic [DW-1:0]   byp_data_r;
  logic            rvld_r;
  logic [DW-1:0]   merged_s;

  assign last_s = (cnt_r == AW'(DEPTH - 1));
  // A read that coincides with ram_clr is dropped so no valid result lands inside the sweep.
  assign accept_rd_s = (state_r == READY) & ram_ren & ~ram_clr;
  assign accept_wr_s = (state_r == READY) & ram_wen;

  // Clear sequencer: sweep every address once, then serve user traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= CLEAR;
      cnt_r       <= '0;
      init_busy_r <= 1'b1;
    end else begin
      case (state_r)
        CLEAR: begin
          if (last_s) begin
            state_r     <= READY;
            init_busy_r <= 1'b0;
            cnt_r       <= '0;
          end else begin
            cnt_r <= cnt_r + AW'(1);
          end
        end
        READY: begin
          if (ram_clr) begin
            state_r     <= CLEAR;
            init_busy_r <= 1'b1;
            cnt_r       <= '0;
          end
        end
        default: begin
          state_r     <= CLEAR;
          init_busy_r <= 1'b1;
          cnt_r       <= '0;
        end
      endcase
    end
  end

  // Storage array and raw read port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (state_r == CLEAR) begin
      mem[cnt_r] <= '0;
    end else if (accept_wr_s) begin
      for (int i = 0; i < BW; i++) begin
        if (ram_wbe[i]) begin
          mem[ram_wadr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
      end
    end
    if (accept_rd_s) begin
      raw_r <= mem[ram_radr];
    end
  end

  // Collision bypass capture. Reset forces a full-lane hit on zero data so the
  // merged output reads 0 before any real read has been accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_r      <= 1'b1;
      byp_be_r   <= '1;
      byp_data_r <= '0;
      rvld_r     <= 1'b0;
    end else begin
      rvld_r <= accept_rd_s;
      if (accept_rd_s) begin
        hit_r      <= accept_wr_s & (ram_radr == ram_wadr);
        byp_be_r   <= ram_wbe;
        byp_data_r <= ram_wdata;
      end
    end
  end

  // Per-lane write-first merge of the bypassed write data over the old array word.
  always_comb begin
    merged_s = raw_r;
    for (int i = 0; i < BW; i++) begin
      if (hit_r && byp_be_r[i]) begin
        merged_s[8*i +: 8] = byp_data_r[8*i +: 8];
      end else begin
        merged_s[8*i +: 8] = raw_r[8*i +: 8];
      end
    end
  end

`ifdef RAM_OUT_REG_EN
  logic          busy_next_s;
  logic [DW-1:0] out_data_r;
  logic          out_vld_r;

  // Busy level the FSM will present after the next edge; used to flush the output stage.
  always_comb begin
    case (state_r)
      CLEAR:   busy_next_s = ~last_s;
      READY:   busy_next_s = ram_clr;
      default: busy_next_s = 1'b1;
    endcase
  end

  // Extra output pipeline stage; data only advances with a valid result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r <= '0;
      out_vld_r  <= 1'b0;
    end else if (busy_next_s) begin
      out_vld_r <= 1'b0;
    end else begin
      out_vld_r <= rvld_r;
      if (rvld_r) begin
        out_data_r <= merged_s;
      end
    end
  end

  assign ram_rdata = out_data_r;
  assign ram_rvld  = out_vld_r;
`else
  assign ram_rdata = merged_s;
  assign ram_rvld  = rvld_r;
`endif

  assign init_busy = init_busy_r;

endmodule

// File: tb/tb_ram_1r1w_be.sv
// Scoreboard bench for ram_1r1w_be: a reference model predicts read results and busy state;
// expected reads are queued at acceptance and popped when the result is due.
module tb_ram_1r1w_be;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int BW    = 4;
`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] ram_radr;
  logic          ram_ren;
  logic [DW-1:0] ram_rdata;
  logic          ram_rvld;
  logic [AW-1:0] ram_wadr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wen;
  logic [BW-1:0] ram_wbe;
  logic          ram_clr;
  logic          init_busy;

  ram_1r1w_be #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ram_radr(ram_radr), .ram_ren(ram_ren), .ram_rdata(ram_rdata), .ram_rvld(ram_rvld),
    .ram_wadr(ram_wadr), .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_wbe(ram_wbe),
    .ram_clr(ram_clr), .init_busy(init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            total;
  int            bad;
  int            cyc;
  logic [DW-1:0] mdl [DEPTH];
  logic          mdl_busy;
  int            mdl_cnt;
  logic [DW-1:0] last_rdata;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_idle();
    ram_ren   = 1'b0;
    ram_radr  = '0;
    ram_wen   = 1'b0;
    ram_wadr  = '0;
    ram_wdata = '0;
    ram_wbe   = '0;
    ram_clr   = 1'b0;
  endtask

  // One clock: model update at the edge, output checks on the following falling edge.
  task automatic tick();
    exp_t e;
    logic ev;
    @(posedge clk);
    cyc++;
    if (mdl_busy) begin
      mdl[mdl_cnt] = '0;
      if (mdl_cnt == DEPTH - 1) mdl_busy = 1'b0;
      else mdl_cnt++;
    end else begin
      if (ram_wen) begin
        for (int i = 0; i < BW; i++)
          if (ram_wbe[i]) mdl[ram_wadr][8*i +: 8] = ram_wdata[8*i +: 8];
      end
      if (ram_ren && !ram_clr) begin
        e.due  = cyc + LAT - 1;
        e.data = mdl[ram_radr];
        exp_q.push_back(e);
      end
      if (ram_clr) begin
        mdl_busy = 1'b1;
        mdl_cnt  = 0;
      end
    end
    @(negedge clk);
    check_eq("busy", {31'b0, init_busy}, {31'b0, mdl_busy});
    ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    check_eq("rvld", {31'b0, ram_rvld}, {31'b0, ev});
    if (ev) begin
      e = exp_q.pop_front();
      check_eq("rdata", ram_rdata, e.data);
      last_rdata = e.data;
    end else begin
      check_eq("hold", ram_rdata, last_rdata);
    end
  endtask

  task automatic drv(input logic ren, input logic [AW-1:0] radr, input logic wen,
                     input logic [AW-1:0] wadr, input logic [DW-1:0] wdata,
                     input logic [BW-1:0] wbe, input logic clr);
    ram_ren = ren; ram_radr = radr; ram_wen = wen; ram_wadr = wadr;
    ram_wdata = wdata; ram_wbe = wbe; ram_clr = clr;
    tick();
    set_idle();
  endtask

  task automatic idle(input int n);
    set_idle();
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_rdata", ram_rdata, 32'h0);
    check_eq("rst_rvld", {31'b0, ram_rvld}, 32'h0);
    check_eq("rst_busy", {31'b0, init_busy}, 32'h1);
    mdl_busy   = 1'b1;
    mdl_cnt    = 0;
    last_rdata = '0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Count busy cycles (bounded); optionally issue a write+read to 0x030 while busy.
  task automatic wait_clear(input logic poke, output int n);
    n = 0;
    while (init_busy && n < DEPTH + 8) begin
      if (poke && n == 3) begin
        ram_wen = 1'b1; ram_wadr = 10'h030; ram_wdata = 32'hFFFFFFFF; ram_wbe = 4'hF;
        ram_ren = 1'b1; ram_radr = 10'h030;
      end else begin
        set_idle();
      end
      tick();
      n++;
    end
    set_idle();
  endtask

  int n;

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0;
    set_idle();
    mdl_busy = 1'b1; mdl_cnt = 0; last_rdata = '0;
    @(negedge clk);
    do_reset();
    wait_clear(1'b0, n);
    check_eq("busy_len_reset", n, DEPTH);

    drv(1'b1, 10'h005, 1'b0, '0, '0, '0, 1'b0);
    idle(2);

    drv(1'b0, '0, 1'b1, 10'h010, 32'hDEADBEEF, 4'b1111, 1'b0);
    drv(1'b0, '0, 1'b1, 10'h010, 32'h11223344, 4'b0101, 1'b0);
    drv(1'b1, 10'h010, 1'b0, '0, '0, '0, 1'b0);
    idle(2);

    drv(1'b0, '0, 1'b1, 10'h3FF, 32'h12345678, 4'b1111, 1'b0);
    drv(1'b1, 10'h3FF, 1'b1, 10'h3FF, 32'hA5A5A5A5, 4'b0011, 1'b0);
    idle(2);

    drv(1'b1, 10'h010, 1'b0, '0, '0, '0, 1'b0);
    drv(1'b1, 10'h3FF, 1'b0, '0, '0, '0, 1'b0);
    idle(1);
    drv(1'b1, 10'h005, 1'b0, '0, '0, '0, 1'b0);
    idle(2);

    drv(1'b0, '0, 1'b1, 10'h040, 32'hCAFEF00D, 4'b1111, 1'b0);
    drv(1'b1, 10'h040, 1'b1, 10'h041, 32'h0BADF00D, 4'b1111, 1'b0);
    drv(1'b1, 10'h041, 1'b0, '0, '0, '0, 1'b0);
    idle(2);

    drv(1'b0, '0, 1'b1, 10'h020, 32'h12121212, 4'b1111, 1'b1);
    wait_clear(1'b1, n);
    check_eq("busy_len_clr", n, DEPTH);
    drv(1'b1, 10'h030, 1'b0, '0, '0, '0, 1'b0);
    drv(1'b1, 10'h020, 1'b0, '0, '0, '0, 1'b0);
    drv(1'b1, 10'h010, 1'b0, '0, '0, '0, 1'b0);
    idle(2);

    drv(1'b0, '0, 1'b1, 10'h010, 32'h55AA55AA, 4'b1111, 1'b0);
    drv(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
    idle(99);
    do_reset();
    wait_clear(1'b0, n);
    check_eq("busy_len_midrst", n, DEPTH);
    drv(1'b1, 10'h010, 1'b0, '0, '0, '0, 1'b0);
    idle(2);

    for (int i = 0; i < 300; i++) begin
      ram_ren   = 1'($urandom_range(0, 1));
      ram_radr  = AW'($urandom_range(0, 7));
      ram_wen   = 1'($urandom_range(0, 1));
      ram_wadr  = AW'($urandom_range(0, 7));
      ram_wdata = DW'($urandom);
      ram_wbe   = BW'($urandom_range(0, 15));
      ram_clr   = 1'b0;
      tick();
    end
    idle(3);
    check_eq("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
